// File: rtl/mmio_io_hub_pkg.sv
// rtl/mmio_io_hub_pkg.sv - register offsets and control bit indices for the IO hub
package mmio_io_hub_pkg;

  localparam logic [9:0] OFF_SW_DATA   = 10'h000;
  localparam logic [9:0] OFF_SW_EDGE   = 10'h004;
  localparam logic [9:0] OFF_LED_DATA  = 10'h008;
  localparam logic [9:0] OFF_LED_BLINK = 10'h00C;
  localparam logic [9:0] OFF_LED_CTRL  = 10'h010;
  localparam logic [9:0] OFF_CYCLE_CNT = 10'h014;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_PHASE_BIT = 1;

endpackage

// File: rtl/mmio_io_hub_sw_debounce.sv
// rtl/mmio_io_hub_sw_debounce.sv - switch synchroniser and tick-sampled debouncer
module sw_debounce #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_data,
  output logic [WIDTH-1:0] sw_data_next
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;
  logic [WIDTH-1:0] stable;

  // A bit is accepted only if it reads the same on two consecutive ticks
  always_comb begin
    sync1_d    = sw_in;
    sync2_d    = sync1_q;
    sample_d   = sample_q;
    deb_d      = deb_q;
    tick       = (tick_cnt_q == CNT_MAX);
    tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);
    stable     = ~(sync2_q ^ sample_q);
    if (tick) begin
      deb_d    = (deb_q & ~stable) | (sync2_q & stable);
      sample_d = sync2_q;
    end
  end

  // State registers, all cleared by reset
  always_ff @(posedge clock) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      sample_q   <= '0;
      deb_q      <= '0;
      tick_cnt_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sample_q   <= sample_d;
      deb_q      <= deb_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign sw_data      = deb_q;
  assign sw_data_next = deb_d;

endmodule

// File: rtl/mmio_io_hub.sv
// rtl/mmio_io_hub.sv - memory-mapped switch/LED/cycle-counter peripheral
module mmio_io_hub
  import mmio_io_hub_pkg::*;
#(
  parameter int SW_WIDTH        = 16,
  parameter int LED_WIDTH       = 16,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int BLINK_DIV       = 4194304
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 io_sel,
  input  logic                 io_read,
  input  logic                 io_write,
  input  logic [9:0]           addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  input  logic [SW_WIDTH-1:0]  sw_in,
  output logic [LED_WIDTH-1:0] led_out
);

  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

  logic [SW_WIDTH-1:0]  sw_data, sw_data_next;
  logic [SW_WIDTH-1:0]  sw_edge_q, sw_edge_d;
  logic [LED_WIDTH-1:0] led_data_q, led_data_d;
  logic [LED_WIDTH-1:0] led_blink_q, led_blink_d;
  logic                 led_en_q, led_en_d;
  logic                 phase_q, phase_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic [31:0]          cycle_cnt_q, cycle_cnt_d;
  logic [LED_WIDTH-1:0] led_out_q, led_out_d;
  logic [SW_WIDTH-1:0]  edge_clr;
  logic [9:0]           word_off;
  logic                 wr_en;
  logic                 rd_en;
  logic                 unused_bits;

  assign word_off    = {addr[9:2], 2'b00};
  assign wr_en       = io_sel & io_write;
  assign rd_en       = io_sel & io_read;
  assign unused_bits = ^{addr[1:0], wdata};

  sw_debounce #(
    .WIDTH           (SW_WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .clock        (clock),
    .rst          (rst),
    .sw_in        (sw_in),
    .sw_data      (sw_data),
    .sw_data_next (sw_data_next)
  );

  // Register writes, edge flags (set beats clear), blink prescaler, cycle counter, LED drive
  always_comb begin
    led_data_d  = led_data_q;
    led_blink_d = led_blink_q;
    led_en_d    = led_en_q;
    edge_clr    = '0;
    cycle_cnt_d = cycle_cnt_q + 32'd1;
    if (wr_en) begin
      case (word_off)
        OFF_SW_EDGE:   edge_clr    = wdata[SW_WIDTH-1:0];
        OFF_LED_DATA:  led_data_d  = wdata[LED_WIDTH-1:0];
        OFF_LED_BLINK: led_blink_d = wdata[LED_WIDTH-1:0];
        OFF_LED_CTRL:  led_en_d    = wdata[CTRL_EN_BIT];
        OFF_CYCLE_CNT: cycle_cnt_d = '0;
        default: ;
      endcase
    end
    sw_edge_d   = (sw_edge_q & ~edge_clr) | (sw_data_next ^ sw_data);
    blink_cnt_d = (blink_cnt_q == BLINK_MAX) ? '0 : blink_cnt_q + BLINK_W'(1);
    phase_d     = (blink_cnt_q == BLINK_MAX) ? ~phase_q : phase_q;
    led_out_d   = led_en_q ? (led_data_q & ~(led_blink_q & {LED_WIDTH{~phase_q}})) : '0;
  end

  // State registers; enable is the only bit that comes out of reset set
  always_ff @(posedge clock) begin
    if (rst) begin
      sw_edge_q   <= '0;
      led_data_q  <= '0;
      led_blink_q <= '0;
      led_en_q    <= 1'b1;
      phase_q     <= 1'b0;
      blink_cnt_q <= '0;
      cycle_cnt_q <= '0;
      led_out_q   <= '0;
    end else begin
      sw_edge_q   <= sw_edge_d;
      led_data_q  <= led_data_d;
      led_blink_q <= led_blink_d;
      led_en_q    <= led_en_d;
      phase_q     <= phase_d;
      blink_cnt_q <= blink_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      led_out_q   <= led_out_d;
    end
  end

  // Zero-latency read mux, zero-extended, quiet unless selected for read
  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (word_off)
        OFF_SW_DATA:   rdata = 32'(sw_data);
        OFF_SW_EDGE:   rdata = 32'(sw_edge_q);
        OFF_LED_DATA:  rdata = 32'(led_data_q);
        OFF_LED_BLINK: rdata = 32'(led_blink_q);
        OFF_LED_CTRL: begin
          rdata[CTRL_EN_BIT]    = led_en_q;
          rdata[CTRL_PHASE_BIT] = phase_q;
        end
        OFF_CYCLE_CNT: rdata = cycle_cnt_q;
        default:       rdata = '0;
      endcase
    end
  end

  assign led_out = led_out_q;

endmodule

// File: tb/tb_mmio_io_hub.sv
// tb/tb_mmio_io_hub.sv - scoreboard bench for mmio_io_hub
module tb_mmio_io_hub;

  localparam int SW_W  = 16;
  localparam int LED_W = 16;
  localparam int DEB   = 4;
  localparam int BDIV  = 8;

  logic              clock = 1'b0;
  logic              rst = 1'b1;
  logic              io_sel = 1'b0;
  logic              io_read = 1'b0;
  logic              io_write = 1'b0;
  logic [9:0]        addr = '0;
  logic [31:0]       wdata = '0;
  logic [31:0]       rdata;
  logic [SW_W-1:0]   sw_in = '0;
  logic [LED_W-1:0]  led_out;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] d;

  mmio_io_hub #(
    .SW_WIDTH        (SW_W),
    .LED_WIDTH       (LED_W),
    .DEBOUNCE_CYCLES (DEB),
    .BLINK_DIV       (BDIV)
  ) dut (
    .clock    (clock),
    .rst      (rst),
    .io_sel   (io_sel),
    .io_read  (io_read),
    .io_write (io_write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .sw_in    (sw_in),
    .led_out  (led_out)
  );

  always #5 clock = ~clock;

  // Bench model of elapsed cycles since reset, used to predict tick and blink timing
  always @(posedge clock) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic phase_at(input int k);
    return ((k / BDIV) % 2) == 1;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [9:0] a, output logic [31:0] v);
    io_sel   = 1'b1;
    io_read  = 1'b1;
    io_write = 1'b0;
    addr     = a;
    #1;
    v = rdata;
  endtask

  task automatic expect_rd(input string tag, input logic [9:0] a, input logic [31:0] e);
    logic [31:0] v;
    exp_q.push_back(e);
    rd(a, v);
    check_val(tag, v, exp_q.pop_front());
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] v);
    io_sel   = 1'b1;
    io_read  = 1'b0;
    io_write = 1'b1;
    addr     = a;
    wdata    = v;
    @(negedge clock);
    io_write = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int t_hit;
    int n;

    repeat (3) @(posedge clock);
    @(negedge clock);
    rst = 1'b0;

    // Reset state
    expect_rd("cyc_cnt0", 10'h014, 32'd0);
    @(negedge clock);
    expect_rd("cyc_cnt1", 10'h014, 32'd1);
    @(negedge clock);
    expect_rd("cyc_cnt2", 10'h014, 32'd2);
    expect_rd("rst_sw_data", 10'h000, 32'h0);
    expect_rd("rst_sw_edge", 10'h004, 32'h0);
    expect_rd("rst_led_data", 10'h008, 32'h0);
    expect_rd("rst_led_blink", 10'h00C, 32'h0);
    expect_rd("rst_led_ctrl", 10'h010, {30'h0, phase_at(cyc), 1'b1});
    check_val("rst_led_out", 32'(led_out), 32'h0);

    // Clean switch edge
    sw_in = 16'h00A5;
    lat = 0;
    d = '0;
    while (lat < 14 && d != 32'h00A5) begin
      @(negedge clock);
      lat++;
      rd(10'h000, d);
    end
    check_val("sw_data_a5", d, 32'h00A5);
    check_val("sw_latency_le10", 32'(lat <= 2 + 2 * DEB), 32'd1);
    expect_rd("sw_edge_a5", 10'h004, 32'h00A5);
    wr(10'h004, 32'h0000_0005);
    expect_rd("sw_edge_w1c", 10'h004, 32'h00A0);

    // Bouncing bit0 whose value never holds across two ticks
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (i % DEB == 0) sw_in[0] = ~sw_in[0];
      expect_rd("bounce_sw_data", 10'h000, 32'h00A5);
    end
    repeat (12) @(negedge clock);
    expect_rd("bounce_sw_data_end", 10'h000, 32'h00A5);
    expect_rd("bounce_sw_edge_end", 10'h004, 32'h00A0);

    // Blink
    wr(10'h008, 32'h0000_FFFF);
    wr(10'h00C, 32'h0000_00FF);
    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      exp_q.push_back(phase_at(cyc - 1) ? 32'h0000_FFFF : 32'h0000_FF00);
      check_val("blink_led_out", 32'(led_out), exp_q.pop_front());
      if (i % 8 == 3) expect_rd("blink_phase", 10'h010, {30'h0, phase_at(cyc), 1'b1});
    end
    wr(10'h010, 32'h0000_0000);
    @(negedge clock);
    check_val("led_disabled", 32'(led_out), 32'h0);
    expect_rd("led_ctrl_off", 10'h010, {30'h0, phase_at(cyc), 1'b0});

    // Debounced set of bit3 coinciding with W1C of bit3: set wins
    @(negedge clock);
    sw_in = 16'h00AD;
    t_hit = ((cyc + 7 + DEB - 1) / DEB) * DEB;
    n = 0;
    while (cyc != t_hit - 1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check_val("edge_race_align", 32'(cyc), 32'(t_hit - 1));
    wr(10'h004, 32'h0000_0008);
    expect_rd("edge_race_data", 10'h000, 32'h00AD);
    expect_rd("edge_race_set_wins", 10'h004, 32'h00A8);
    @(negedge clock);
    wr(10'h004, 32'h0000_0008);
    expect_rd("edge_bit3_clear", 10'h004, 32'h00A0);

    // Cycle counter clear
    repeat (100) @(negedge clock);
    wr(10'h014, 32'h1234_5678);
    expect_rd("cyc_clr0", 10'h014, 32'd0);
    @(negedge clock);
    expect_rd("cyc_clr1", 10'h014, 32'd1);
    @(negedge clock);
    expect_rd("cyc_clr2", 10'h014, 32'd2);

    // Unmapped offsets, byte-offset aliasing, width truncation, read gating
    expect_rd("unmapped_18", 10'h018, 32'h0);
    expect_rd("unmapped_3fc", 10'h3FC, 32'h0);
    wr(10'h018, 32'hFFFF_FFFF);
    wr(10'h3FC, 32'hFFFF_FFFF);
    expect_rd("keep_led_data", 10'h008, 32'h0000_FFFF);
    expect_rd("keep_led_blink", 10'h00C, 32'h0000_00FF);
    expect_rd("keep_sw_edge", 10'h004, 32'h00A0);
    expect_rd("keep_led_ctrl", 10'h010, {30'h0, phase_at(cyc), 1'b0});
    expect_rd("alias_0b", 10'h00B, 32'h0000_FFFF);
    wr(10'h008, 32'hABCD_1234);
    expect_rd("trunc_led_data", 10'h008, 32'h0000_1234);
    wr(10'h010, 32'hFFFF_FFFE);
    expect_rd("ctrl_upper_ignored", 10'h010, {30'h0, phase_at(cyc), 1'b0});
    wr(10'h010, 32'hFFFF_FFFF);
    expect_rd("ctrl_enable", 10'h010, {30'h0, phase_at(cyc), 1'b1});
    io_read = 1'b0;
    addr    = 10'h008;
    #1;
    check_val("no_read_strobe", rdata, 32'h0);

    // Reset in mid-operation
    @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
    expect_rd("rerst_cyc", 10'h014, 32'd0);
    expect_rd("rerst_sw_data", 10'h000, 32'h0);
    expect_rd("rerst_sw_edge", 10'h004, 32'h0);
    expect_rd("rerst_led_data", 10'h008, 32'h0);
    expect_rd("rerst_led_blink", 10'h00C, 32'h0);
    expect_rd("rerst_led_ctrl", 10'h010, 32'h1);
    check_val("rerst_led_out", 32'(led_out), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
